// File: rtl/particle_initializer_if.sv
// particle_initializer_if
//   Write-port bundle between the particle initializer and the particle RAM.
//   The initializer drives the request side; the RAM (or an arbiter in front
//   of it) drives the ready.
//   wr_valid_out : write request valid (master -> slave)
//   wr_ready_in  : write accepted when high together with wr_valid_out
//   addr_out     : ADDR_WIDTH-bit word address
//   data_out     : RAM_WIDTH-bit word data
interface particle_initializer_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int RAM_WIDTH  = 64
) ();
   logic                  wr_valid_out;
   logic                  wr_ready_in;
   logic [ADDR_WIDTH-1:0] addr_out;
   logic [RAM_WIDTH-1:0]  data_out;

   modport master (
      output wr_valid_out,
      output addr_out,
      output data_out,
      input  wr_ready_in
   );

   modport slave (
      input  wr_valid_out,
      input  addr_out,
      input  data_out,
      output wr_ready_in
   );
endinterface

// File: rtl/particle_initializer.sv
// particle_initializer
//   On a restart request sweeps the particle RAM, writing a position word at
//   address 2k and a velocity word at address 2k+1 for every particle k.
//   Positions come from per-dimension 16-bit LFSRs (random mode) or from a
//   lattice of grid_w points per axis (grid mode). Velocities are zero or
//   small random fp16 values taken from the current LFSR state.
//   Ports:
//     clk_in            clock, rising edge
//     rst_in            synchronous active-low reset
//     restart_in        start a sweep (only honoured in IDLE)
//     seed_in           LFSR seed, latched on restart
//     particle_count_in particle count, clamped to RAM capacity, latched
//     pos_mode_in       0 random, 1 grid; latched
//     vel_mode_in       0 zero, 1 random; latched
//     grid_w_in         lattice points per axis (0 behaves as 1); latched
//     wr_if             ready/valid write port (master side)
//     busy_out          sweep in progress
//     done_out          one-cycle pulse after the final write is accepted
module particle_initializer #(
   parameter int         ADDR_WIDTH = 12,
   parameter int         DIMS       = 2,
   parameter int         RAM_WIDTH  = 64,
   parameter logic [4:0] POS_EXP    = 5'b01110,
   parameter logic [4:0] VEL_EXP    = 5'b01000
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   restart_in,
   input  logic [15:0]            seed_in,
   input  logic [15:0]            particle_count_in,
   input  logic                   pos_mode_in,
   input  logic                   vel_mode_in,
   input  logic [7:0]             grid_w_in,
   particle_initializer_if.master wr_if,
   output logic                   busy_out,
   output logic                   done_out
);

   localparam logic [31:0] CAPACITY = 32'd1 << (ADDR_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // One Fibonacci step of x^16+x^14+x^13+x^11+1.
   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   // Per-dimension seed; the all-zero lock-up state is never loaded.
   function automatic logic [15:0] lfsr_seed(input logic [15:0] seed, input int d);
      logic [15:0] s;
      s = seed ^ (16'h1111 * 16'(d));
      return (s == 16'h0000) ? 16'h0001 : s;
   endfunction

   state_t                     state_r, state_nxt_s;
   logic [DIMS-1:0][15:0]      lfsr_r, lfsr_nxt_s;
   logic [DIMS-1:0][7:0]       cnt_r, cnt_nxt_s;
   logic                       pos_mode_r, pos_mode_nxt_s;
   logic                       vel_mode_r, vel_mode_nxt_s;
   logic [7:0]                 grid_w_r, grid_w_nxt_s;
   logic [ADDR_WIDTH-1:0]      last_addr_r, last_addr_nxt_s;
   logic [ADDR_WIDTH-1:0]      addr_r, addr_nxt_s;
   logic [RAM_WIDTH-1:0]       data_r, data_nxt_s, word_s;
   logic                       valid_r, busy_r, done_r;
   logic                       load_word_s, carry_s, accept_s;
   logic [31:0]                n_s;

   assign accept_s = valid_r & wr_if.wr_ready_in;
   // Particle count clamped to what the RAM can hold.
   assign n_s = ({16'h0000, particle_count_in} > CAPACITY) ? CAPACITY
                                                            : {16'h0000, particle_count_in};

   // State register.
   always_ff @(posedge clk_in) begin
      if (!rst_in) state_r <= ST_IDLE;
      else         state_r <= state_nxt_s;
   end

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (restart_in) state_nxt_s = (n_s == 32'd0) ? ST_DONE : ST_WRITE;
            else            state_nxt_s = ST_IDLE;
         end
         ST_WRITE: begin
            if (accept_s && (addr_r == last_addr_r)) state_nxt_s = ST_DONE;
            else                                     state_nxt_s = ST_WRITE;
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Next values for the registered datapath and outputs.
   always_comb begin
      lfsr_nxt_s      = lfsr_r;
      cnt_nxt_s       = cnt_r;
      pos_mode_nxt_s  = pos_mode_r;
      vel_mode_nxt_s  = vel_mode_r;
      grid_w_nxt_s    = grid_w_r;
      last_addr_nxt_s = last_addr_r;
      addr_nxt_s      = addr_r;
      load_word_s     = 1'b0;
      carry_s         = 1'b1;
      word_s          = '0;
      data_nxt_s      = data_r;
      case (state_r)
         ST_IDLE: begin
            if (restart_in) begin
               for (int d = 0; d < DIMS; d++) begin
                  lfsr_nxt_s[d] = lfsr_seed(seed_in, d);
                  cnt_nxt_s[d]  = 8'd0;
               end
               pos_mode_nxt_s  = pos_mode_in;
               vel_mode_nxt_s  = vel_mode_in;
               grid_w_nxt_s    = (grid_w_in == 8'd0) ? 8'd1 : grid_w_in;
               last_addr_nxt_s = ADDR_WIDTH'((n_s << 1) - 32'd1);
               addr_nxt_s      = '0;
               load_word_s     = 1'b1;
            end else begin
               load_word_s = 1'b0;
            end
         end
         ST_WRITE: begin
            if (accept_s) begin
               addr_nxt_s  = addr_r + ADDR_WIDTH'(1);
               load_word_s = 1'b1;
               // Generators advance only when a position word leaves.
               if (!addr_r[0]) begin
                  for (int d = 0; d < DIMS; d++) begin
                     lfsr_nxt_s[d] = lfsr_step(lfsr_r[d]);
                     if (carry_s) begin
                        if (cnt_r[d] == grid_w_r - 8'd1) begin
                           cnt_nxt_s[d] = 8'd0;
                        end else begin
                           cnt_nxt_s[d] = cnt_r[d] + 8'd1;
                           carry_s      = 1'b0;
                        end
                     end else begin
                        cnt_nxt_s[d] = cnt_r[d];
                     end
                  end
               end else begin
                  load_word_s = 1'b1;
               end
            end else begin
               load_word_s = 1'b0;
            end
         end
         ST_DONE: load_word_s = 1'b0;
         default: load_word_s = 1'b0;
      endcase

      // Word for the next address, built from the generator state it will see.
      for (int d = 0; d < DIMS; d++) begin
         if (!addr_nxt_s[0]) begin
            if (pos_mode_nxt_s)
               word_s[RAM_WIDTH-1-16*d -: 16] = {1'b0, POS_EXP, cnt_nxt_s[d], 2'b00};
            else
               word_s[RAM_WIDTH-1-16*d -: 16] = {lfsr_nxt_s[d][15], POS_EXP, lfsr_nxt_s[d][9:0]};
         end else if (vel_mode_nxt_s) begin
            word_s[RAM_WIDTH-1-16*d -: 16] = {lfsr_nxt_s[d][14], VEL_EXP, lfsr_nxt_s[d][12:3]};
         end else begin
            word_s[RAM_WIDTH-1-16*d -: 16] = 16'h0000;
         end
      end

      // Outside WRITE the bus returns to its idle values.
      if (state_nxt_s != ST_WRITE) begin
         addr_nxt_s = '0;
         data_nxt_s = '0;
      end else if (load_word_s) begin
         data_nxt_s = word_s;
      end else begin
         data_nxt_s = data_r;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         for (int d = 0; d < DIMS; d++) begin
            lfsr_r[d] <= 16'h0001;
            cnt_r[d]  <= 8'd0;
         end
         pos_mode_r  <= 1'b0;
         vel_mode_r  <= 1'b0;
         grid_w_r    <= 8'd1;
         last_addr_r <= '0;
         addr_r      <= '0;
         data_r      <= '0;
         valid_r     <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         lfsr_r      <= lfsr_nxt_s;
         cnt_r       <= cnt_nxt_s;
         pos_mode_r  <= pos_mode_nxt_s;
         vel_mode_r  <= vel_mode_nxt_s;
         grid_w_r    <= grid_w_nxt_s;
         last_addr_r <= last_addr_nxt_s;
         addr_r      <= addr_nxt_s;
         data_r      <= data_nxt_s;
         valid_r     <= (state_nxt_s == ST_WRITE);
         busy_r      <= (state_nxt_s == ST_WRITE);
         done_r      <= (state_nxt_s == ST_DONE);
      end
   end

   assign wr_if.wr_valid_out = valid_r;
   assign wr_if.addr_out     = addr_r;
   assign wr_if.data_out     = data_r;
   assign busy_out           = busy_r;
   assign done_out           = done_r;

endmodule

// File: tb/tb_particle_initializer.sv
// tb_particle_initializer
//   Table-driven sweeps against two instances (ADDR_WIDTH 12 and 4), each
//   accepted word compared with an independent reference model, followed by
//   hand-written sequences for fixed constants, seeding, clamping and reset.
module tb_particle_initializer;

   typedef struct {
      bit          sel;     // 0: ADDR_WIDTH=12 instance, 1: ADDR_WIDTH=4 instance
      logic [15:0] seed;
      logic [15:0] count;
      bit          pm;
      bit          vm;
      logic [7:0]  gw;
      bit          rnd;     // random ready instead of ready tied high
      bit          poke;    // assert restart mid-sweep and during done
      int          exp_n;
   } vec_t;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        restart12 = 1'b0, restart4 = 1'b0;
   logic [15:0] seed_in = 16'h0000, count_in = 16'h0000;
   logic        pos_mode_in = 1'b0, vel_mode_in = 1'b0;
   logic [7:0]  grid_w_in = 8'h00;
   logic        wr_ready = 1'b0;
   logic        busy12, done12, busy4, done4;
   bit          sel = 1'b0;

   int          errors = 0;
   int          checks = 0;
   logic [63:0] cap[$];
   logic [63:0] cap_a[$];
   logic [11:0] last_addr;
   vec_t        vecs [8];
   logic [15:0] grid_x [5] = '{16'h3800, 16'h3804, 16'h3800, 16'h3804, 16'h3800};
   logic [15:0] grid_y [5] = '{16'h3800, 16'h3800, 16'h3804, 16'h3804, 16'h3800};

   particle_initializer_if #(.ADDR_WIDTH(12), .RAM_WIDTH(64)) if12 ();
   particle_initializer_if #(.ADDR_WIDTH(4),  .RAM_WIDTH(64)) if4 ();

   assign if12.wr_ready_in = wr_ready;
   assign if4.wr_ready_in  = wr_ready;

   particle_initializer #(.ADDR_WIDTH(12), .DIMS(2), .RAM_WIDTH(64)) dut12 (
      .clk_in(clk_in), .rst_in(rst_in), .restart_in(restart12), .seed_in(seed_in),
      .particle_count_in(count_in), .pos_mode_in(pos_mode_in), .vel_mode_in(vel_mode_in),
      .grid_w_in(grid_w_in), .wr_if(if12), .busy_out(busy12), .done_out(done12));

   particle_initializer #(.ADDR_WIDTH(4), .DIMS(2), .RAM_WIDTH(64)) dut4 (
      .clk_in(clk_in), .rst_in(rst_in), .restart_in(restart4), .seed_in(seed_in),
      .particle_count_in(count_in), .pos_mode_in(pos_mode_in), .vel_mode_in(vel_mode_in),
      .grid_w_in(grid_w_in), .wr_if(if4), .busy_out(busy4), .done_out(done4));

   logic        m_valid, m_busy, m_done;
   logic [11:0] m_addr;
   logic [63:0] m_data;
   assign m_valid = sel ? if4.wr_valid_out : if12.wr_valid_out;
   assign m_busy  = sel ? busy4 : busy12;
   assign m_done  = sel ? done4 : done12;
   assign m_addr  = sel ? {8'h00, if4.addr_out} : if12.addr_out;
   assign m_data  = sel ? if4.data_out : if12.data_out;

   always #5 clk_in = ~clk_in;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic set_restart(input bit which, input logic val);
      if (which) restart4 = val;
      else       restart12 = val;
   endtask

   // Reference: expected word at an address, by stepping the LFSRs from the seed.
   function automatic logic [63:0] model_word(input logic [15:0] seed, input bit pm, input bit vm,
                                              input logic [7:0] gw, input int addr);
      logic [15:0] l [2];
      logic [15:0] comp;
      logic [7:0]  c;
      logic [63:0] w;
      int          k, g, steps;
      k = addr / 2;
      g = (gw == 8'd0) ? 1 : int'(gw);
      l[0] = seed;
      l[1] = seed ^ 16'h1111;
      for (int d = 0; d < 2; d++) if (l[d] == 16'h0000) l[d] = 16'h0001;
      steps = (addr % 2 == 0) ? k : k + 1;
      for (int s = 0; s < steps; s++)
         for (int d = 0; d < 2; d++)
            l[d] = {l[d][14:0], l[d][15] ^ l[d][13] ^ l[d][12] ^ l[d][10]};
      w = 64'h0;
      for (int d = 0; d < 2; d++) begin
         c = (d == 0) ? 8'(k % g) : 8'((k / g) % g);
         if (addr % 2 == 0)
            comp = pm ? {1'b0, 5'b01110, c, 2'b00} : {l[d][15], 5'b01110, l[d][9:0]};
         else
            comp = vm ? {l[d][14], 5'b01000, l[d][12:3]} : 16'h0000;
         w[63-16*d -: 16] = comp;
      end
      return w;
   endfunction

   task automatic run_sweep(input vec_t v);
      int          acc, cyc;
      bit          stalled;
      logic [11:0] paddr;
      logic [63:0] pdata;
      cap.delete();
      sel         = v.sel;
      seed_in     = v.seed;
      count_in    = v.count;
      pos_mode_in = v.pm;
      vel_mode_in = v.vm;
      grid_w_in   = v.gw;
      set_restart(v.sel, 1'b1);
      step();
      set_restart(v.sel, 1'b0);
      if (v.exp_n == 0) begin
         chk("zero_done", 64'(m_done), 64'd1);
         chk("zero_valid", 64'(m_valid), 64'd0);
         chk("zero_busy", 64'(m_busy), 64'd0);
         step();
         chk("zero_done_once", 64'(m_done), 64'd0);
         chk("zero_valid_after", 64'(m_valid), 64'd0);
         return;
      end
      chk("first_valid", 64'(m_valid), 64'd1);
      chk("first_busy", 64'(m_busy), 64'd1);
      chk("first_addr", 64'(m_addr), 64'd0);
      acc = 0; cyc = 0; stalled = 1'b0; paddr = '0; pdata = '0;
      while (acc < 2 * v.exp_n && cyc < 40 * v.exp_n + 20) begin
         if (stalled) begin
            chk("stall_valid", 64'(m_valid), 64'd1);
            chk("stall_addr", 64'(m_addr), 64'(paddr));
            chk("stall_data", m_data, pdata);
         end
         wr_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (m_valid && wr_ready) begin
            chk("wr_addr", 64'(m_addr), 64'(acc));
            chk("wr_data", m_data, model_word(v.seed, v.pm, v.vm, v.gw, acc));
            cap.push_back(m_data);
            last_addr = m_addr;
            if (v.poke && acc == 2) begin
               set_restart(v.sel, 1'b1);
               seed_in  = ~v.seed;
               count_in = 16'd1;
            end
            acc++;
            stalled = 1'b0;
         end else begin
            stalled = m_valid;
            paddr   = m_addr;
            pdata   = m_data;
         end
         step();
         set_restart(v.sel, 1'b0);
         cyc++;
      end
      wr_ready = 1'b0;
      chk("accept_count", 64'(acc), 64'(2 * v.exp_n));
      chk("done_pulse", 64'(m_done), 64'd1);
      chk("done_valid", 64'(m_valid), 64'd0);
      chk("done_busy", 64'(m_busy), 64'd0);
      if (v.poke) set_restart(v.sel, 1'b1);
      step();
      set_restart(v.sel, 1'b0);
      chk("done_once", 64'(m_done), 64'd0);
      chk("idle_valid", 64'(m_valid), 64'd0);
      step();
      chk("idle_valid2", 64'(m_valid), 64'd0);
   endtask

   initial begin
      //          sel   seed      count   pm    vm    gw     rnd   poke  N
      vecs[0] = '{1'b0, 16'hACE1, 16'd3,  1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 3};
      vecs[1] = '{1'b0, 16'hACE1, 16'd3,  1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 3};
      vecs[2] = '{1'b0, 16'h1234, 16'd5,  1'b1, 1'b0, 8'd2, 1'b0, 1'b0, 5};
      vecs[3] = '{1'b0, 16'h0000, 16'd4,  1'b0, 1'b1, 8'd0, 1'b1, 1'b1, 4};
      vecs[4] = '{1'b1, 16'hBEEF, 16'd20, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 8};
      vecs[5] = '{1'b1, 16'h0005, 16'd0,  1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 0};
      vecs[6] = '{1'b0, 16'h00FF, 16'd6,  1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 6};
      vecs[7] = '{1'b0, 16'h1111, 16'd4,  1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 4};

      rst_in = 1'b0;
      repeat (3) step();
      chk("rst_valid12", 64'(if12.wr_valid_out), 64'd0);
      chk("rst_busy12", 64'(busy12), 64'd0);
      chk("rst_done12", 64'(done12), 64'd0);
      chk("rst_addr12", 64'(if12.addr_out), 64'd0);
      chk("rst_data12", if12.data_out, 64'd0);
      chk("rst_valid4", 64'(if4.wr_valid_out), 64'd0);
      chk("rst_done4", 64'(done4), 64'd0);
      rst_in = 1'b1;
      step();

      for (int i = 0; i < 8; i++) run_sweep(vecs[i]);

      // Hand-computed constants for seed ACE1 with random velocities.
      run_sweep(vecs[1]);
      chk("ace1_size", 64'(cap.size()), 64'd6);
      chk("ace1_pos0", cap[0], 64'hB8E1_B9F0_0000_0000);
      chk("ace1_vel0_x", 64'(cap[1][63:48]), 64'hA338);
      chk("ace1_exp_x", 64'(cap[2][62:58]), 64'(5'b01110));
      cap_a = cap;

      // Same seed with ready tied high gives the bit-identical sequence.
      vecs[1].rnd = 1'b0;
      run_sweep(vecs[1]);
      for (int i = 0; i < 6; i++) chk("same_seed", cap[i], cap_a[i]);

      // A different seed changes the first x slice.
      vecs[1].seed = 16'hACE2;
      run_sweep(vecs[1]);
      chk("seed_differs", 64'(cap[0][63:48] != cap_a[0][63:48]), 64'd1);

      // Lattice with two points per axis.
      run_sweep(vecs[2]);
      for (int k = 0; k < 5; k++) begin
         chk("grid_x", 64'(cap[2*k][63:48]), 64'(grid_x[k]));
         chk("grid_y", 64'(cap[2*k][47:32]), 64'(grid_y[k]));
      end

      // Count clamped to 8 particles on the 4-bit-address instance.
      run_sweep(vecs[4]);
      chk("clamp_last_addr", 64'(last_addr), 64'd15);

      // Reset during word 3 aborts the sweep.
      sel = 1'b0;
      seed_in = 16'h1357; count_in = 16'd6; pos_mode_in = 1'b0; vel_mode_in = 1'b1;
      wr_ready = 1'b1;
      restart12 = 1'b1;
      step();
      restart12 = 1'b0;
      for (int n = 0; n < 10 && m_addr != 12'd3; n++) step();
      chk("rst_reach_word3", 64'(m_addr), 64'd3);
      rst_in = 1'b0;
      step();
      chk("midrst_valid", 64'(m_valid), 64'd0);
      chk("midrst_busy", 64'(m_busy), 64'd0);
      chk("midrst_addr", 64'(m_addr), 64'd0);
      chk("midrst_data", m_data, 64'd0);
      chk("midrst_done", 64'(m_done), 64'd0);
      rst_in = 1'b1;
      for (int n = 0; n < 3; n++) begin
         step();
         chk("midrst_no_write", 64'(m_valid), 64'd0);
      end
      wr_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
